// File: rtl/gf32_pkg.sv
// rtl/gf32_pkg.sv - shared constants and FSM state type for the GF(2^5) Montgomery exponentiator
package gf32_pkg;

    // Field width and reduction polynomial P(x) = x^5 + x^2 + 1
    localparam int          GF_W     = 5;
    localparam logic [5:0]  P_POLY   = 6'b100101;

    // Montgomery form of 1: R mod P = x^5 mod P = x^2 + 1
    localparam logic [4:0]  MONT_ONE = 5'b00101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/gf32_mont_mul.sv
// rtl/gf32_mont_mul.sv - combinational Montgomery multiplier z = a*b*x^-5 mod P over GF(2^5)
//
// Ports:
//   a_i [4:0]  operand, Montgomery form
//   b_i [4:0]  operand, Montgomery form
//   z_o [4:0]  a*b*x^-5 mod P, fully reduced
module gf32_mont_mul
    import gf32_pkg::*;
(
    input  logic [GF_W-1:0] a_i,
    input  logic [GF_W-1:0] b_i,
    output logic [GF_W-1:0] z_o
);

    logic [GF_W-1:0] z_acc;
    logic [GF_W:0]   t;

    // Bit-serial Montgomery reduction, unrolled: for each bit of a, add b if the
    // bit is set, cancel the constant term with P (P has a constant 1) and divide by x.
    // After GF_W steps the accumulator holds a*b*x^-GF_W, already of degree < GF_W.
    always_comb begin
        z_acc = '0;
        t     = '0;
        for (int i = 0; i < GF_W; i++) begin
            t = {1'b0, z_acc} ^ (a_i[i] ? {1'b0, b_i} : '0);
            if (t[0]) begin
                t = t ^ P_POLY;
            end
            z_acc = t[GF_W:1];
        end
    end

    assign z_o = z_acc;

endmodule

// File: rtl/gf32_mont_pow.sv
// rtl/gf32_mont_pow.sv - constant-time left-to-right square-and-multiply exponentiator in GF(2^5) Montgomery domain
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, taken only while in_ready=1
//   base[4:0]  base operand, Montgomery form
//   exp[EXP_W-1:0]  exponent, MSB processed first
//   in_ready   high in IDLE
//   busy       high while squaring/multiplying
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   result[4:0]  base^exp in Montgomery form, registered
module gf32_mont_pow
    import gf32_pkg::*;
#(
    parameter int EXP_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [GF_W-1:0]  base,
    input  logic [EXP_W-1:0] exp,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [GF_W-1:0]  result
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_t           state_q;
    logic [GF_W-1:0]  acc_q;
    logic [GF_W-1:0]  base_q;
    logic [EXP_W-1:0] exp_q;
    logic [IDX_W-1:0] idx_q;
    logic [GF_W-1:0]  result_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;

    logic [GF_W-1:0]  op_b;
    logic [GF_W-1:0]  prod;
    logic [GF_W-1:0]  acc_d;

    // Second operand is acc everywhere except MUL; acc only moves on active
    // cycles and run start, so the multiplier inputs stay quiet in IDLE/DONE.
    assign op_b = (state_q == MUL) ? base_q : acc_q;

    gf32_mont_mul u_mul (
        .a_i (acc_q),
        .b_i (op_b),
        .z_o (prod)
    );

    // The multiply result is always computed in MUL; the exponent bit only
    // selects whether it is kept, so the schedule never depends on exp.
    assign acc_d = exp_q[idx_q] ? prod : acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q     <= base;
                        exp_q      <= exp;
                        acc_q      <= MONT_ONE;
                        idx_q      <= IDX_W'(EXP_W - 1);
                        state_q    <= SQR;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SQR: begin
                    acc_q   <= prod;
                    state_q <= MUL;
                end
                MUL: begin
                    acc_q <= acc_d;
                    if (idx_q == '0) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        result_q    <= acc_d;
                    end else begin
                        idx_q   <= idx_q - IDX_W'(1);
                        state_q <= SQR;
                    end
                end
                DONE: begin
                    // in_ready is low here, so a coincident start is dropped
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: doc/gf32_mont_pow.md
# gf32_mont_pow

Sequential Montgomery-domain exponentiator over GF(2^5), P(x) = x^5 + x^2 + 1, Montgomery radix R = x^5. It wraps a single combinational Montgomery multiplier (a·b·x^-5 mod P) and feeds it operands cycle by cycle. It runs constant-time left-to-right square-and-multiply, so one multiplier serves power, inversion and other higher-level field operations. Operands and result stay in the Montgomery domain, so the output can go straight back into the multiplier.

## Interface
- EXP_W, 5, exponent width in bits; fixes latency at 2·EXP_W cycles
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when in_ready=1
- base  input  5  base operand, Montgomery form (b·x^5 mod P)
- exp  input  EXP_W  unsigned integer exponent, MSB processed first
- in_ready  output  1  high in IDLE only
- busy  output  1  high in SQR/MUL
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- result  output  5  b^exp in Montgomery form (b^exp·x^5 mod P)

## Operation
- States: IDLE, SQR, MUL, DONE.
- IDLE:
  - in_ready=1.
  - start=1 → latch base into base_r and exp into exp_r; acc ← MONT_ONE (5'b00101 = x^5 mod P); bit index ← EXP_W-1; go to SQR.
- SQR: acc ← mont(acc, acc); go to MUL.
- MUL:
  - prod = mont(acc, base_r) is always computed.
  - acc ← prod if exp_r[index]=1, else acc is unchanged.
  - If index=0, go to DONE; otherwise decrement index and go to SQR.
  - The multiply always runs, whatever the exponent bit, so timing is independent of exp.
- DONE:
  - out_valid=1; result = acc.
  - out_valid & out_ready at a clock edge → IDLE.
- Multiplier input mux: SQR drives (acc, acc); MUL drives (acc, base_r). In IDLE/DONE the mux inputs are don't-care, but they are held stable to avoid toggling.
- Arithmetic: all additions are XOR, carry-free. The multiplier output is already reduced to 5 bits. There is no integer carry anywhere.
- Boundaries:
  - exp=0 → result 5'b00101.
  - base=5'b00000 with exp≠0 → 5'b00000.
  - start while not in IDLE is ignored; the latched operands are never overwritten mid-run.
  - start and out_ready in the same cycle as a DONE→IDLE transition: start is ignored, because in_ready was low that cycle.
  - out_ready while not in DONE has no effect.
- Reset (asserted at any time, including mid-run): immediately forces IDLE; acc, result, base_r, exp_r and index clear to 0; the in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, busy=0, out_valid=0, result=5'b00000.
- Start is accepted at edge T. Edges T+1 … T+2·EXP_W perform the alternating SQR/MUL operations, one multiplication per cycle.
- out_valid rises after edge T+2·EXP_W, i.e. 10 cycles after acceptance at default EXP_W.
- busy is high from after edge T until after edge T+2·EXP_W.
- result is registered: it is stable and glitch-free while out_valid=1, and holds its last value after acceptance until the next run completes.
- Back-to-back runs: minimum spacing is 2·EXP_W + 2 cycles (DONE accept → IDLE → start).

## Structure
- Package gf32_pkg contains:
  - GF_W=5;
  - P_POLY=6'b100101;
  - MONT_ONE=5'b00101;
  - state enum {IDLE, SQR, MUL, DONE}.
- Sub-module gf32_mont_mul: purely combinational, a[4:0], b[4:0] → z = a·b·x^-5 mod P. It is instantiated once, and the verification model is checked against it standalone.
- Top level: FSM, index counter, acc/base_r/exp_r registers, operand mux.

## Test plan
- Reset: assert rst_n=0 mid-run (after 4 cycles) → out_valid=0, in_ready=1, result=0 immediately; the next run completes normally.
- base=5'b00010, exp=2 → result=5'b10110 (x^-3) after exactly 10 cycles; out_valid held across 3 cycles of out_ready=0.
- base=5'b00010, exp=3 → result=5'b11110 (x^-7); base=5'b00010, exp=1 → 5'b00010.
- exp=0 with any base → 5'b00101; base=5'b00101 (one), exp=31 → 5'b00101; base=0, exp=7 → 0.
- start pulsed during busy with different base/exp → ignored; result matches the first request; latency stays 10 cycles for all exp values.
- Random 1000 runs against a software GF(2^5) model (b^e·x^5 mod P), with random out_ready back-pressure → all results match and no handshake is lost or duplicated.
